// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: a six-entry code table is loaded on code_valid, and bits
// are shifted in MSB-first. A matching code emits its symbol index one cycle later.
module huffman_decoder (
   input  logic       clk,
   input  logic       reset,
   input  logic       code_valid,
   input  logic [7:0] HC1,
   input  logic [7:0] HC2,
   input  logic [7:0] HC3,
   input  logic [7:0] HC4,
   input  logic [7:0] HC5,
   input  logic [7:0] HC6,
   input  logic [7:0] M1,
   input  logic [7:0] M2,
   input  logic [7:0] M3,
   input  logic [7:0] M4,
   input  logic [7:0] M5,
   input  logic [7:0] M6,
   input  logic       bit_valid,
   input  logic       bit_in,
   output logic       table_ready,
   output logic       sym_valid,
   output logic [7:0] sym_data,
   output logic       err,
   output logic [6:0] sym_count,
   output logic       done
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [5:0][7:0] hc_q, hc_d;
   logic [5:0][3:0] ln_q, ln_d;
   logic [3:0]      lmax_q, lmax_d;
   logic [7:0]      acc_q, acc_d;
   logic [3:0]      len_q, len_d;
   logic            ready_q, ready_d;
   logic            sym_valid_q, sym_valid_d;
   logic [7:0]      sym_data_q, sym_data_d;
   logic            err_q, err_d;
   logic [6:0]      count_q, count_d;
   logic            done_q, done_d;

   logic [5:0][7:0] hc_in_s;
   logic [5:0][7:0] m_in_s;
   logic [5:0][3:0] new_len_s;
   logic [3:0]      new_lmax_s;
   logic [7:0]      acc_n_s;
   logic [3:0]      len_n_s;
   logic [5:0]      match_s;
   logic [2:0]      hit_idx_s;

   function automatic logic [3:0] popcount8(input logic [7:0] m);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 8; i++) c = c + {3'd0, m[i]};
      return c;
   endfunction

   function automatic logic [7:0] len_mask(input logic [3:0] l);
      logic [7:0] m;
      for (int i = 0; i < 8; i++) m[i] = (4'(i) < l);
      return m;
   endfunction

   assign hc_in_s = {HC6, HC5, HC4, HC3, HC2, HC1};
   assign m_in_s  = {M6, M5, M4, M3, M2, M1};
   assign acc_n_s = {acc_q[6:0], bit_in};
   assign len_n_s = len_q + 4'd1;

   // Code lengths and longest length of the table presented on the inputs.
   always_comb begin
      new_lmax_s = 4'd0;
      for (int i = 0; i < 6; i++) begin
         new_len_s[i] = popcount8(m_in_s[i]);
         if (new_len_s[i] > new_lmax_s) new_lmax_s = new_len_s[i];
         else                           new_lmax_s = new_lmax_s;
      end
   end

   // Match every table entry against the shifted accumulator; lowest index wins.
   always_comb begin
      hit_idx_s = 3'd0;
      for (int i = 0; i < 6; i++) begin
         match_s[i] = (ln_q[i] != 4'd0) && (len_n_s == ln_q[i]) &&
                      ((acc_n_s & len_mask(ln_q[i])) == (hc_q[i] & len_mask(ln_q[i])));
      end
      for (int i = 5; i >= 0; i--) begin
         if (match_s[i]) hit_idx_s = 3'(i + 1);
         else            hit_idx_s = hit_idx_s;
      end
   end

   // Next-state and output logic for the IDLE/RUN/DONE controller.
   always_comb begin
      state_d     = state_q;
      hc_d        = hc_q;
      ln_d        = ln_q;
      lmax_d      = lmax_q;
      acc_d       = acc_q;
      len_d       = len_q;
      sym_valid_d = 1'b0;
      sym_data_d  = 8'd0;
      err_d       = 1'b0;
      count_d     = count_q;
      done_d      = done_q;
      case (state_q)
         IDLE, RUN, DONE: begin
            if (code_valid) begin
               hc_d    = hc_in_s;
               ln_d    = new_len_s;
               lmax_d  = new_lmax_s;
               acc_d   = 8'd0;
               len_d   = 4'd0;
               count_d = 7'd0;
               done_d  = 1'b0;
               state_d = RUN;
            end else if ((state_q == RUN) && bit_valid) begin
               if (match_s != 6'd0) begin
                  sym_valid_d = 1'b1;
                  sym_data_d  = {5'd0, hit_idx_s};
                  count_d     = count_q + 7'd1;
                  acc_d       = 8'd0;
                  len_d       = 4'd0;
                  if (count_q == 7'd99) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = RUN;
                  end
               end else if (len_n_s >= lmax_q) begin
                  // An empty table (lmax 0) lands here on every bit.
                  err_d = 1'b1;
                  acc_d = 8'd0;
                  len_d = 4'd0;
               end else begin
                  acc_d = acc_n_s;
                  len_d = len_n_s;
               end
            end else begin
               state_d = state_q;
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         hc_q        <= '0;
         ln_q        <= '0;
         lmax_q      <= 4'd0;
         acc_q       <= 8'd0;
         len_q       <= 4'd0;
         ready_q     <= 1'b0;
         sym_valid_q <= 1'b0;
         sym_data_q  <= 8'd0;
         err_q       <= 1'b0;
         count_q     <= 7'd0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hc_q        <= hc_d;
         ln_q        <= ln_d;
         lmax_q      <= lmax_d;
         acc_q       <= acc_d;
         len_q       <= len_d;
         ready_q     <= ready_d;
         sym_valid_q <= sym_valid_d;
         sym_data_q  <= sym_data_d;
         err_q       <= err_d;
         count_q     <= count_d;
         done_q      <= done_d;
      end
   end

   assign table_ready = ready_q;
   assign sym_valid   = sym_valid_q;
   assign sym_data    = sym_data_q;
   assign err         = err_q;
   assign sym_count   = count_q;
   assign done        = done_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder: a table of single-code vectors plus
// hand-written sequences for gaps, errors, saturation, reload and reset.
module tb_huffman_decoder;

   logic       clk = 1'b0;
   logic       reset, code_valid, bit_valid, bit_in;
   logic [7:0] HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6;
   logic       table_ready, sym_valid, err, done;
   logic [7:0] sym_data;
   logic [6:0] sym_count;

   int         pass_cnt = 0;
   int         total_cnt = 0;
   logic [7:0] got_q[$];
   int         err_seen = 0;
   int         both_seen = 0;

   localparam logic [47:0] T_HC  = {8'h1F, 8'h1E, 8'h0E, 8'h06, 8'h02, 8'h00};
   localparam logic [47:0] T_M   = {8'h1F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};
   localparam logic [47:0] T_M6Z = {8'h00, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};

   typedef struct {
      logic [7:0] bits;
      int         nbits;
      logic [7:0] exp_sym;
      logic [6:0] exp_cnt;
   } vec_t;

   vec_t vecs[6];

   huffman_decoder dut (
      .clk(clk), .reset(reset), .code_valid(code_valid),
      .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
      .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
      .bit_valid(bit_valid), .bit_in(bit_in),
      .table_ready(table_ready), .sym_valid(sym_valid), .sym_data(sym_data),
      .err(err), .sym_count(sym_count), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (sym_valid === 1'b1) got_q.push_back(sym_data);
      if (err === 1'b1) err_seen++;
      if (sym_valid === 1'b1 && err === 1'b1) both_seen++;
   endtask

   task automatic send_bit(input logic b);
      bit_valid = 1'b1;
      bit_in    = b;
      tick();
      bit_valid = 1'b0;
      bit_in    = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic load(input logic [47:0] hc, input logic [47:0] m);
      {HC6, HC5, HC4, HC3, HC2, HC1} = hc;
      {M6, M5, M4, M3, M2, M1}       = m;
      code_valid = 1'b1;
      tick();
      code_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, {31'd0, table_ready}, 32'd0);
      chk({tag, "_sym_valid"}, {31'd0, sym_valid}, 32'd0);
      chk({tag, "_sym_data"}, {24'd0, sym_data}, 32'd0);
      chk({tag, "_err"}, {31'd0, err}, 32'd0);
      chk({tag, "_count"}, {25'd0, sym_count}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      vecs[0] = '{8'b0,     1, 8'h01, 7'd1};
      vecs[1] = '{8'b10,    2, 8'h02, 7'd2};
      vecs[2] = '{8'b110,   3, 8'h03, 7'd3};
      vecs[3] = '{8'b1110,  4, 8'h04, 7'd4};
      vecs[4] = '{8'b11110, 5, 8'h05, 7'd5};
      vecs[5] = '{8'b11111, 5, 8'h06, 7'd6};

      reset = 1'b1; code_valid = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
      {HC6, HC5, HC4, HC3, HC2, HC1} = '0;
      {M6, M5, M4, M3, M2, M1}       = '0;
      idle(2);
      check_reset_outputs("reset");
      reset = 1'b0;

      // Bits before any table load are ignored.
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      idle(1);
      chk("v5_ready", {31'd0, table_ready}, 32'd0);
      chk("v5_no_sym", got_q.size(), 32'd0);
      chk("v5_no_err", err_seen, 32'd0);

      load(T_HC, T_M);
      chk("load_ready", {31'd0, table_ready}, 32'd1);
      chk("load_count", {25'd0, sym_count}, 32'd0);

      // Table-driven single-code vectors, MSB first.
      for (int v = 0; v < 6; v++) begin
         for (int b = vecs[v].nbits - 1; b >= 0; b--) send_bit(vecs[v].bits[b]);
         chk($sformatf("vec%0d_valid", v), {31'd0, sym_valid}, 32'd1);
         chk($sformatf("vec%0d_data", v), {24'd0, sym_data}, {24'd0, vecs[v].exp_sym});
         chk($sformatf("vec%0d_err", v), {31'd0, err}, 32'd0);
         chk($sformatf("vec%0d_count", v), {25'd0, sym_count}, {25'd0, vecs[v].exp_cnt});
         idle(1);
         chk($sformatf("vec%0d_pulse_end", v), {31'd0, sym_valid}, 32'd0);
      end

      // V1 on a fresh table: 110 -> 3 with count 1.
      load(T_HC, T_M);
      send_bit(1'b1); send_bit(1'b1);
      chk("v1_early", {31'd0, sym_valid}, 32'd0);
      send_bit(1'b0);
      chk("v1_valid", {31'd0, sym_valid}, 32'd1);
      chk("v1_data", {24'd0, sym_data}, 32'h03);
      chk("v1_count", {25'd0, sym_count}, 32'd1);

      // V2: gaps inside codes.
      load(T_HC, T_M);
      got_q.delete(); err_seen = 0;
      send_bit(1'b0);
      send_bit(1'b1); idle(2); send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b1); idle(2); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); idle(2); send_bit(1'b0);
      idle(1);
      chk("v2_num", got_q.size(), 32'd4);
      if (got_q.size() == 4) begin
         chk("v2_s0", {24'd0, got_q[0]}, 32'h01);
         chk("v2_s1", {24'd0, got_q[1]}, 32'h02);
         chk("v2_s2", {24'd0, got_q[2]}, 32'h06);
         chk("v2_s3", {24'd0, got_q[3]}, 32'h04);
      end
      chk("v2_no_err", err_seen, 32'd0);

      // V3: 11111 has no code once M6 is cleared.
      load(T_HC, T_M6Z);
      for (int k = 0; k < 4; k++) send_bit(1'b1);
      chk("v3_no_early_err", {31'd0, err}, 32'd0);
      send_bit(1'b1);
      chk("v3_err", {31'd0, err}, 32'd1);
      chk("v3_no_sym", {31'd0, sym_valid}, 32'd0);
      chk("v3_count", {25'd0, sym_count}, 32'd0);
      send_bit(1'b0);
      chk("v3_after_valid", {31'd0, sym_valid}, 32'd1);
      chk("v3_after_data", {24'd0, sym_data}, 32'h01);
      chk("v3_after_err", {31'd0, err}, 32'd0);

      // Duplicate codes report the lowest index; HC bits above the length are ignored.
      load({8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'hFE}, {8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h03});
      send_bit(1'b1); send_bit(1'b0);
      chk("dup_valid", {31'd0, sym_valid}, 32'd1);
      chk("dup_data", {24'd0, sym_data}, 32'h01);
      send_bit(1'b0);
      chk("dup_partial", {31'd0, err}, 32'd0);
      send_bit(1'b0);
      chk("dup_err", {31'd0, err}, 32'd1);

      // Empty table: every valid bit is an error.
      load('0, '0);
      send_bit(1'b1);
      chk("empty_err0", {31'd0, err}, 32'd1);
      send_bit(1'b0);
      chk("empty_err1", {31'd0, err}, 32'd1);
      chk("empty_count", {25'd0, sym_count}, 32'd0);

      // V4: saturate at 100 symbols, then reload.
      load(T_HC, T_M);
      for (int k = 0; k < 100; k++) begin
         send_bit(1'b0);
         if (k == 98) begin
            chk("v4_count99", {25'd0, sym_count}, 32'd99);
            chk("v4_done99", {31'd0, done}, 32'd0);
         end
      end
      chk("v4_count100", {25'd0, sym_count}, 32'd100);
      chk("v4_done", {31'd0, done}, 32'd1);
      send_bit(1'b0);
      chk("v4_ignored", {31'd0, sym_valid}, 32'd0);
      chk("v4_hold", {25'd0, sym_count}, 32'd100);
      chk("v4_ready", {31'd0, table_ready}, 32'd1);
      bit_valid = 1'b1; bit_in = 1'b0;
      load(T_HC, T_M);
      bit_valid = 1'b0;
      chk("reload_done", {31'd0, done}, 32'd0);
      chk("reload_count", {25'd0, sym_count}, 32'd0);
      idle(1);
      chk("reload_discard", {31'd0, sym_valid}, 32'd0);
      send_bit(1'b1); send_bit(1'b0);
      chk("reload_data", {24'd0, sym_data}, 32'h02);

      // V6: asynchronous reset in the middle of a code.
      load(T_HC, T_M);
      send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b1);
      reset = 1'b1;
      #1;
      check_reset_outputs("v6_async");
      got_q.delete(); err_seen = 0;
      idle(1);
      reset = 1'b0;
      idle(3);
      chk("v6_no_sym", got_q.size(), 32'd0);
      chk("v6_no_err", err_seen, 32'd0);
      chk("v6_idle_ready", {31'd0, table_ready}, 32'd0);
      load(T_HC, T_M);
      send_bit(1'b1); send_bit(1'b0);
      chk("v6_valid", {31'd0, sym_valid}, 32'd1);
      chk("v6_data", {24'd0, sym_data}, 32'h02);

      chk("never_both", both_seen, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/huffman_decoder.md
HUFFMAN_DECODER -- requirements
Module: huffman_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port code_valid, input, 1 bit: one-cycle pulse that loads the code table.
REQ-004 SHALL have ports HC1..HC6, input, 8 bits each: code bits, LSB-aligned; bit 0 is the leaf-most bit.
REQ-005 SHALL have ports M1..M6, input, 8 bits each: contiguous-from-bit-0 validity mask; code length Li = popcount(Mi).
REQ-006 SHALL have ports bit_valid and bit_in, input, 1 bit each: serial code stream, one bit per cycle when bit_valid=1.
REQ-007 SHALL have port table_ready, output, 1 bit: a table is loaded and decoding is enabled.
REQ-008 SHALL have port sym_valid, output, 1 bit: one-cycle pulse marking a decoded symbol.
REQ-009 SHALL have port sym_data, output, 8 bits: decoded gray value 8'h01..8'h06; valid only when sym_valid=1.
REQ-010 SHALL have port err, output, 1 bit: one-cycle pulse when no code matches.
REQ-011 SHALL have port sym_count, output, 7 bits: number of symbols decoded since the last table load.
REQ-012 SHALL have port done, output, 1 bit: level, high once 100 symbols have been decoded.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE; reset state is IDLE.
REQ-014 In IDLE, SHALL ignore bit_valid; on code_valid=1, SHALL latch HC1..6 and M1..6, compute L1..L6 and Lmax = max(Li), clear the accumulator, and go to RUN.
REQ-015 In RUN, on each bit_valid=1, SHALL form acc' = {acc[6:0], bit_in} and len' = len+1; the first transmitted bit is the MSB of the code, bit Li-1.
REQ-016 Symbol i SHALL match when Li != 0, len' == Li, and acc'[Li-1:0] == HCi[Li-1:0]; HCi bits above Li-1 SHALL be ignored.
REQ-017 On a match, SHALL assert sym_valid=1 and sym_data=i on the next cycle (1-cycle latency), increment sym_count, and clear acc/len in the same cycle as the match.
REQ-018 If several symbols match (non-prefix-free table), SHALL report the lowest index.
REQ-019 On no match with len' == Lmax, SHALL pulse err the next cycle, clear acc/len, and leave sym_count unchanged.
REQ-020 A table with all Mi=0 (Lmax=0) SHALL pulse err on every valid bit.
REQ-021 When sym_count reaches 100, SHALL go to DONE and hold done=1; in DONE, bit_valid SHALL be ignored.
REQ-022 code_valid in RUN or DONE SHALL reload the table, clear acc, len, sym_count and done, and enter RUN; a bit_valid in the same cycle SHALL be discarded.
REQ-023 bit_valid=0 SHALL hold acc/len unchanged, so gaps of any length are allowed mid-code.
REQ-024 table_ready SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-025 sym_valid and err SHALL never both be 1 in the same cycle.

Reset
REQ-026 Asserting reset SHALL immediately force state=IDLE, table_ready=0, sym_valid=0, sym_data=0, err=0, sym_count=0, done=0, acc=0, len=0, and clear the stored table.
REQ-027 Reset asserted mid-code SHALL discard the partial code, and no sym_valid or err pulse SHALL follow.

Verification
Common table T: HC/M = 00/01, 02/03, 06/07, 0E/0F, 1E/1F, 1F/1F, giving codes 0, 10, 110, 1110, 11110, 11111.
V1: load T, send bits 1,1,0 -> sym_valid one cycle after the third bit, sym_data=8'h03, sym_count=1.
V2: load T, send 0,10,11111,1110 with 2-cycle gaps inserted mid-code -> sym_data 1,2,6,4 in order, no err.
V3: load T with M6=0, send 1,1,1,1,1 -> err pulse after the fifth bit, no sym_valid, acc cleared; a following 0 decodes to 8'h01.
V4: load T, send 100 codes of 0 -> sym_count=100, done=1; a further bit 0 produces no sym_valid; code_valid then clears done and sym_count.
V5: bit_valid pulses before any code_valid -> no outputs, table_ready=0.
V6: reset asserted after bits 1,1 -> all outputs 0, state IDLE; after reload of T, send 1,0 -> sym_data=8'h02.
